mc_datapath: RTL

Multi-cycle MIPS-subset datapath with its own sequencer. It is the parametrised successor of the single-cycle datapath.
- One unified instruction/data memory port with a req/ready handshake, so memory wait states are tolerated.
- Width and reset vector are configurable.
- Sits between the top-level testbench/SoC memory model and nothing else; it is self-contained, with no external controller.

---
 rtl/mc_pkg.sv | 68 ++++++
 rtl/mc_regfile.sv | 30 +++
 rtl/mc_datapath.sv | 220 ++++++++++++++++++++++
 3 files changed

// File: rtl/mc_pkg.sv
// Shared definitions for the multi-cycle MIPS-subset datapath: sequencer states,
// instruction encodings, ALU operations and the decode helpers used by the top.
package mc_pkg;

   typedef enum logic [2:0] {
      ST_BOOT,
      ST_FETCH,
      ST_DECODE,
      ST_EXEC,
      ST_MEM,
      ST_WB,
      ST_TRAP
   } state_e;

   typedef enum logic [2:0] {
      ALU_ADD,
      ALU_SUB,
      ALU_AND,
      ALU_OR,
      ALU_SLT
   } alu_op_e;

   localparam logic [5:0] OP_RTYPE = 6'h00;
   localparam logic [5:0] OP_LW    = 6'h23;
   localparam logic [5:0] OP_SW    = 6'h2B;
   localparam logic [5:0] OP_BEQ   = 6'h04;
   localparam logic [5:0] OP_ADDI  = 6'h08;
   localparam logic [5:0] OP_J     = 6'h02;
   localparam logic [5:0] OP_JAL   = 6'h03;

   localparam logic [5:0] FN_ADD = 6'h20;
   localparam logic [5:0] FN_SUB = 6'h22;
   localparam logic [5:0] FN_AND = 6'h24;
   localparam logic [5:0] FN_OR  = 6'h25;
   localparam logic [5:0] FN_SLT = 6'h2A;
   localparam logic [5:0] FN_JR  = 6'h08;

   // Anything not listed here traps; R-type is legal only for the known functs.
   function automatic logic is_legal(input logic [5:0] op, input logic [5:0] fn);
      logic ok;
      ok = 1'b0;
      case (op)
         OP_RTYPE: ok = (fn == FN_ADD) || (fn == FN_SUB) || (fn == FN_AND) ||
                        (fn == FN_OR)  || (fn == FN_SLT) || (fn == FN_JR);
         OP_LW, OP_SW, OP_BEQ, OP_ADDI, OP_J, OP_JAL: ok = 1'b1;
         default: ok = 1'b0;
      endcase
      return ok;
   endfunction

   function automatic alu_op_e alu_op_of(input logic [5:0] op, input logic [5:0] fn);
      alu_op_e r;
      r = ALU_ADD;
      if (op == OP_BEQ) begin
         r = ALU_SUB;
      end else if (op == OP_RTYPE) begin
         case (fn)
            FN_SUB:  r = ALU_SUB;
            FN_AND:  r = ALU_AND;
            FN_OR:   r = ALU_OR;
            FN_SLT:  r = ALU_SLT;
            default: r = ALU_ADD;
         endcase
      end
      return r;
   endfunction

endpackage

// File: rtl/mc_regfile.sv
// General-purpose register file: two combinational read ports, one synchronous
// write port. Register 0 reads as zero and ignores writes; contents are not reset.
module mc_regfile
   import mc_pkg::*;
#(
   parameter int DATA_W = 32,
   parameter int NREGS  = 32
) (
   input  logic                     clk,
   input  logic [$clog2(NREGS)-1:0] ra_a,
   input  logic [$clog2(NREGS)-1:0] ra_b,
   output logic [DATA_W-1:0]        rd_a,
   output logic [DATA_W-1:0]        rd_b,
   input  logic                     we,
   input  logic [$clog2(NREGS)-1:0] wa,
   input  logic [DATA_W-1:0]        wd
);

   logic [DATA_W-1:0] regs_q [NREGS];

   always_ff @(posedge clk) begin
      if (we && (wa != '0)) begin
         regs_q[wa] <= wd;
      end
   end

   assign rd_a = (ra_a == '0) ? '0 : regs_q[ra_a];
   assign rd_b = (ra_b == '0) ? '0 : regs_q[ra_b];

endmodule

// File: rtl/mc_datapath.sv
// Multi-cycle MIPS-subset datapath with its own sequencer and a single shared
// instruction/data memory port that tolerates wait states.
module mc_datapath
   import mc_pkg::*;
#(
   parameter int                DATA_W   = 32,
   parameter logic [DATA_W-1:0] RESET_PC = '0,
   parameter int                NREGS    = 32
) (
   input  logic              clk,
   input  logic              rst,
   output logic              mem_req,
   output logic              mem_we,
   output logic [DATA_W-1:0] mem_addr,
   output logic [DATA_W-1:0] mem_wdata,
   input  logic [DATA_W-1:0] mem_rdata,
   input  logic              mem_ready,
   output logic              halted,
   output logic [DATA_W-1:0] dbg_pc,
   output logic [31:0]       instret
);

   localparam int AW = $clog2(NREGS);

   state_e            state_q, state_d;
   logic [DATA_W-1:0] pc_q, pc_d;
   logic [31:0]       ir_q, ir_d;
   logic [DATA_W-1:0] mdr_q, mdr_d;
   logic [DATA_W-1:0] a_q, a_d;
   logic [DATA_W-1:0] b_q, b_d;
   logic [DATA_W-1:0] alu_out_q, alu_out_d;
   logic [31:0]       instret_q, instret_d;

   logic [5:0]        opcode, funct;
   logic [AW-1:0]     rs_idx, rt_idx, rd_idx;
   logic [DATA_W-1:0] imm_sext, br_off, jmp_tgt;
   logic [DATA_W-1:0] rf_rd_a, rf_rd_b;
   logic              rf_we;
   logic [AW-1:0]     rf_wa;
   logic [DATA_W-1:0] rf_wd;
   logic              retire;
   alu_op_e           alu_op;
   logic [DATA_W-1:0] alu_b, alu_res;
   logic              unused_shamt;

   // Register indices are taken modulo NREGS by keeping only the low bits.
   assign opcode   = ir_q[31:26];
   assign funct    = ir_q[5:0];
   assign rs_idx   = ir_q[21 +: AW];
   assign rt_idx   = ir_q[16 +: AW];
   assign rd_idx   = ir_q[11 +: AW];
   assign imm_sext = {{(DATA_W-16){ir_q[15]}}, ir_q[15:0]};
   assign br_off   = {imm_sext[DATA_W-3:0], 2'b00};
   assign jmp_tgt  = {pc_q[DATA_W-1:28], ir_q[25:0], 2'b00};
   assign unused_shamt = ^ir_q[10:6];

   mc_regfile #(
      .DATA_W (DATA_W),
      .NREGS  (NREGS)
   ) u_rf (
      .clk  (clk),
      .ra_a (rs_idx),
      .ra_b (rt_idx),
      .rd_a (rf_rd_a),
      .rd_b (rf_rd_b),
      .we   (rf_we),
      .wa   (rf_wa),
      .wd   (rf_wd)
   );

   always_comb begin
      alu_op  = alu_op_of(opcode, funct);
      alu_b   = ((opcode == OP_RTYPE) || (opcode == OP_BEQ)) ? b_q : imm_sext;
      alu_res = '0;
      case (alu_op)
         ALU_ADD: alu_res = a_q + alu_b;
         ALU_SUB: alu_res = a_q - alu_b;
         ALU_AND: alu_res = a_q & alu_b;
         ALU_OR:  alu_res = a_q | alu_b;
         ALU_SLT: alu_res[0] = ($signed(a_q) < $signed(alu_b));
         default: alu_res = '0;
      endcase
   end

   // Memory handshake: an access is presented while mem_req=1 and completes on
   // the rising edge where mem_ready=1; address, we and wdata come from state or
   // registers that do not change until that edge, so they hold through stalls.
   // mem_ready is ignored whenever mem_req=0.
   always_comb begin
      state_d   = state_q;
      pc_d      = pc_q;
      ir_d      = ir_q;
      mdr_d     = mdr_q;
      a_d       = a_q;
      b_d       = b_q;
      alu_out_d = alu_out_q;
      retire    = 1'b0;
      rf_we     = 1'b0;
      rf_wa     = '0;
      rf_wd     = '0;
      mem_req   = 1'b0;
      mem_we    = 1'b0;
      mem_addr  = pc_q;

      case (state_q)
         ST_BOOT: begin
            state_d = ST_FETCH;
         end

         ST_FETCH: begin
            mem_req = 1'b1;
            if (mem_ready) begin
               ir_d    = mem_rdata[31:0];
               pc_d    = pc_q + DATA_W'(4);
               state_d = ST_DECODE;
            end
         end

         ST_DECODE: begin
            a_d = rf_rd_a;
            b_d = rf_rd_b;
            if (!is_legal(opcode, funct)) begin
               state_d = ST_TRAP;
            end else if ((opcode == OP_J) || (opcode == OP_JAL)) begin
               pc_d    = jmp_tgt;
               retire  = 1'b1;
               state_d = ST_FETCH;
               // pc_q already holds the incremented PC, which is the link value.
               if (opcode == OP_JAL) begin
                  rf_we = 1'b1;
                  rf_wa = '1;
                  rf_wd = pc_q;
               end
            end else if ((opcode == OP_RTYPE) && (funct == FN_JR)) begin
               pc_d    = rf_rd_a;
               retire  = 1'b1;
               state_d = ST_FETCH;
            end else begin
               state_d = ST_EXEC;
            end
         end

         ST_EXEC: begin
            alu_out_d = alu_res;
            if (opcode == OP_BEQ) begin
               if (a_q == b_q) begin
                  pc_d = pc_q + br_off;
               end
               retire  = 1'b1;
               state_d = ST_FETCH;
            end else if ((opcode == OP_LW) || (opcode == OP_SW)) begin
               state_d = ST_MEM;
            end else begin
               state_d = ST_WB;
            end
         end

         ST_MEM: begin
            mem_req  = 1'b1;
            mem_we   = (opcode == OP_SW);
            mem_addr = alu_out_q;
            if (mem_ready) begin
               if (opcode == OP_SW) begin
                  retire  = 1'b1;
                  state_d = ST_FETCH;
               end else begin
                  mdr_d   = mem_rdata;
                  state_d = ST_WB;
               end
            end
         end

         ST_WB: begin
            rf_we   = 1'b1;
            rf_wa   = (opcode == OP_RTYPE) ? rd_idx : rt_idx;
            rf_wd   = (opcode == OP_LW) ? mdr_q : alu_out_q;
            retire  = 1'b1;
            state_d = ST_FETCH;
         end

         ST_TRAP: begin
            state_d = ST_TRAP;
         end

         default: begin
            state_d = ST_TRAP;
         end
      endcase

      instret_d = instret_q + 32'(retire);
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q   <= ST_BOOT;
         pc_q      <= RESET_PC;
         ir_q      <= '0;
         mdr_q     <= '0;
         a_q       <= '0;
         b_q       <= '0;
         alu_out_q <= '0;
         instret_q <= '0;
      end else begin
         state_q   <= state_d;
         pc_q      <= pc_d;
         ir_q      <= ir_d;
         mdr_q     <= mdr_d;
         a_q       <= a_d;
         b_q       <= b_d;
         alu_out_q <= alu_out_d;
         instret_q <= instret_d;
      end
   end

   assign mem_wdata = b_q;
   assign halted    = (state_q == ST_TRAP);
   assign dbg_pc    = pc_q;
   assign instret   = instret_q;

endmodule
